// File: rtl/pipe_pkg.sv
// pipe_pkg: constants shared by the pipeline boundary registers.
//   - WB control bit positions inside the MEM/WB control bundle.
//   - Control/data widths for each classic 5-stage boundary.
//   - Bubble (no-op) control value for each boundary.
//   - wb_ctrl(): builds a MEM/WB control bundle from named bits.
package pipe_pkg;

  // MEM/WB control bundle layout: {reg_write, mem_to_reg}
  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;

  // Per-boundary widths
  localparam int IF_ID_CTRL_W  = 1;    // {pred_taken}
  localparam int IF_ID_DATA_W  = 64;   // pc + instruction
  localparam int ID_EX_CTRL_W  = 8;    // alu op, src sel, mem rd/wr, wb bits
  localparam int ID_EX_DATA_W  = 111;  // pc + rs1 + rs2 values, three reg indices
  localparam int EX_MEM_CTRL_W = 4;    // {mem_read, mem_write, reg_write, mem_to_reg}
  localparam int EX_MEM_DATA_W = 69;   // alu result + store data + rd
  localparam int MEM_WB_CTRL_W = 2;    // {reg_write, mem_to_reg}
  localparam int MEM_WB_DATA_W = 69;   // load data + alu result + rd

  // Bubble control values: all-zero means no register/memory side effects
  localparam logic [IF_ID_CTRL_W-1:0]  IF_ID_BUBBLE  = '0;
  localparam logic [ID_EX_CTRL_W-1:0]  ID_EX_BUBBLE  = '0;
  localparam logic [EX_MEM_CTRL_W-1:0] EX_MEM_BUBBLE = '0;
  localparam logic [MEM_WB_CTRL_W-1:0] MEM_WB_BUBBLE = '0;

  function automatic logic [MEM_WB_CTRL_W-1:0] wb_ctrl(input logic reg_write,
                                                       input logic mem_to_reg);
    logic [MEM_WB_CTRL_W-1:0] c;
    c                = '0;
    c[WB_REG_WRITE]  = reg_write;
    c[WB_MEM_TO_REG] = mem_to_reg;
    return c;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: all handshake/bus signals of one pipeline boundary.
//   Upstream side : in_valid, in_ready, in_ctrl, in_data, flush
//   Downstream side: out_valid, out_ready, out_ctrl, out_data
// Modports:
//   master - the surrounding pipeline (drives inputs, observes outputs)
//   slave  - the stage register itself
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int CTRL_W = MEM_WB_CTRL_W,
  parameter int DATA_W = MEM_WB_DATA_W
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_ctrl, in_data, flush, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, flush, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_slot.sv
// pipe_slot: one {valid, ctrl, data} holding register.
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset (clears everything)
//   load_i          - capture ctrl_i/data_i and mark valid
//   clear_i         - drop the valid bit only; ctrl/data keep their value
//   ctrl_i, data_i  - value to capture
//   valid_o, ctrl_o, data_o - held contents
// clear_i wins over load_i; with neither asserted the slot holds bit-exactly.
module pipe_slot #(
  parameter int CTRL_W = 2,
  parameter int DATA_W = 69
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);
  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: reusable pipeline boundary register (IF/ID .. MEM/WB).
// Ports:
//   clk, rst_n - clock, synchronous active-low reset
//   bus        - pipe_stage_reg_if.slave: in_valid/in_ready/in_ctrl/in_data,
//                flush, out_valid/out_ready/out_ctrl/out_data
//   stall_cnt, flush_cnt - only when PIPE_STAGE_PERF_EN is defined
// A main slot drives the outputs; a skid slot catches the one entry that
// arrives while downstream stalls, so in_ready can be a plain register
// (~skid valid) with no combinational path from out_ready.
// Optional macro PIPE_STAGE_PERF_EN adds stall/flush performance counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                CTRL_W      = MEM_WB_CTRL_W,
  parameter int                DATA_W      = MEM_WB_DATA_W,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  pipe_stage_reg_if.slave bus
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]    stall_cnt,
  output logic [15:0]    flush_cnt
`endif
);
  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_d;
  logic [DATA_W-1:0] main_data, skid_data, main_data_d;
  logic              main_load, main_clear, skid_load, skid_clear;
  logic              up_xfer, dn_xfer;
  logic              in_ready_q, in_ready_d;

  assign up_xfer = bus.in_valid & in_ready_q;
  assign dn_xfer = main_valid & bus.out_ready;

  always_comb begin
    main_load   = 1'b0;
    main_clear  = 1'b0;
    skid_load   = 1'b0;
    skid_clear  = 1'b0;
    main_ctrl_d = bus.in_ctrl;
    main_data_d = bus.in_data;
    if (bus.flush) begin
      // Nothing loads on a flush; an entry leaving this cycle is already gone.
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (skid_valid) begin
      // FULL: in_ready is low, so only the drain towards main can happen.
      if (dn_xfer) begin
        main_load   = 1'b1;
        main_ctrl_d = skid_ctrl;
        main_data_d = skid_data;
        skid_clear  = 1'b1;
      end
    end else if (up_xfer) begin
      if (!main_valid || dn_xfer) main_load = 1'b1;
      else                        skid_load = 1'b1;
    end else if (dn_xfer) begin
      main_clear = 1'b1;
    end
  end

  // in_ready for next cycle is the inverse of the skid valid being written.
  assign in_ready_d = ~(skid_load | (skid_valid & ~skid_clear));

  always_ff @(posedge clk) begin
    if (!rst_n) in_ready_q <= 1'b1;
    else        in_ready_q <= in_ready_d;
  end

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (main_load),
    .clear_i (main_clear),
    .ctrl_i  (main_ctrl_d),
    .data_i  (main_data_d),
    .valid_o (main_valid),
    .ctrl_o  (main_ctrl),
    .data_o  (main_data)
  );

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .ctrl_i  (bus.in_ctrl),
    .data_i  (bus.in_data),
    .valid_o (skid_valid),
    .ctrl_o  (skid_ctrl),
    .data_o  (skid_data)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_valid;
  assign bus.out_ctrl  = main_valid ? main_ctrl : CTRL_BUBBLE;
  assign bus.out_data  = main_data;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;
  logic        flush_kill;

  // A flush only counts when it actually destroys something: a skid entry,
  // a main entry downstream did not take, or an entry accepted this cycle.
  assign flush_kill = bus.flush &
                      (skid_valid | (main_valid & ~bus.out_ready) | up_xfer);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (main_valid && !bus.out_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_kill)                   flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
endmodule
